// File: rtl/piece_lock_clear_if.sv
// Bundle between the falling-piece controller (master) and the lock/clear
// stage (slave).
//
// Handshake: lock_req is a one-cycle request. It is taken only when busy=0
// and game_over=0; at any other time it is dropped, not queued. x0..x3 and
// y0..y3 must stay stable from the request until done. done is a one-cycle
// completion pulse. After done, board, lines_this, lines_total, score and
// game_over are valid. new_game is taken only while busy=0.
interface piece_lock_clear_if #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int SCORE_W = 20
);
  logic                       lock_req;
  logic                       new_game;
  logic [4:0]                 x0, x1, x2, x3;
  logic [5:0]                 y0, y1, y2, y3;
  logic [ROWS-1:0][COLS-1:0]  board;
  logic                       busy;
  logic                       done;
  logic [2:0]                 lines_this;
  logic [15:0]                lines_total;
  logic [SCORE_W-1:0]         score;
  logic                       game_over;
  logic [2:0]                 state_dbg;

  modport master (
    output lock_req, new_game, x0, x1, x2, x3, y0, y1, y2, y3,
    input  board, busy, done, lines_this, lines_total, score, game_over,
           state_dbg
  );

  modport slave (
    input  lock_req, new_game, x0, x1, x2, x3, y0, y1, y2, y3,
    output board, busy, done, lines_this, lines_total, score, game_over,
           state_dbg
  );
endinterface

// File: rtl/piece_lock_clear.sv
// Lock the active piece into the playfield, collapse full rows, and update
// the line counters, the score and the game-over flag.
module piece_lock_clear #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int SCORE_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  piece_lock_clear_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_SCAN  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t                    state, state_nxt;
  logic [ROWS-1:0][COLS-1:0] board_q;
  logic [ROWS-1:0][COLS-1:0] write_mask;
  logic [RW-1:0]             r;
  logic [2:0]                n;
  logic                      ovf;
  logic                      cell_ovf;
  logic                      row_full;
  logic                      drop_full;
  logic [4:0]                cx [4];
  logic [5:0]                cy [4];
  logic [SCORE_W:0]          score_sum;
  logic [16:0]               lines_sum;

  function automatic logic [10:0] score_inc(input logic [2:0] cnt);
    case (cnt)
      3'd0:    return 11'd0;
      3'd1:    return 11'd40;
      3'd2:    return 11'd100;
      3'd3:    return 11'd300;
      default: return 11'd1200;
    endcase
  endfunction

  // Per-row mask of the piece cells that land inside the field, plus the
  // overflow flag for cells above it (off-field columns are just dropped).
  always_comb begin
    cx = '{bus.x0, bus.x1, bus.x2, bus.x3};
    cy = '{bus.y0, bus.y1, bus.y2, bus.y3};
    write_mask = '0;
    cell_ovf   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cy[i] >= 6'(ROWS)) cell_ovf = 1'b1;
      for (int yy = 0; yy < ROWS; yy++) begin
        if (cy[i] == 6'(yy) && cx[i] < 5'(COLS))
          write_mask[yy] = write_mask[yy] | (COLS'(1) << cx[i]);
      end
    end
  end

  // Row tests and saturating counter sums. During a shift the row about to
  // drop into r is tested in the same cycle, so each cleared row costs one
  // extra cycle instead of a shift plus a separate rescan.
  always_comb begin
    row_full  = &board_q[r];
    drop_full = (r != LAST_ROW) ? &board_q[r + RW'(1)] : 1'b0;
    score_sum = {1'b0, bus.score} + (SCORE_W + 1)'(score_inc(n));
    lines_sum = {1'b0, bus.lines_total} + 17'(n);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.state_dbg = state;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (!bus.new_game && bus.lock_req) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = S_SCAN;
      S_SCAN: begin
        if (row_full)              state_nxt = S_SHIFT;
        else if (r == LAST_ROW)    state_nxt = S_DONE;
      end
      S_SHIFT: begin
        if (drop_full)             state_nxt = S_SHIFT;
        else if (r == LAST_ROW)    state_nxt = S_DONE;
        else                       state_nxt = S_SCAN;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = ovf ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        bus.busy = 1'b0;
        if (bus.new_game) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Playfield, row pointer, clear count and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q         <= '0;
      r               <= '0;
      n               <= '0;
      ovf             <= 1'b0;
      bus.lines_this  <= '0;
      bus.lines_total <= '0;
      bus.score       <= '0;
      bus.game_over   <= 1'b0;
    end else if ((state == S_IDLE || state == S_OVER) && bus.new_game) begin
      board_q         <= '0;
      r               <= '0;
      n               <= '0;
      ovf             <= 1'b0;
      bus.lines_this  <= '0;
      bus.lines_total <= '0;
      bus.score       <= '0;
      bus.game_over   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.lock_req) begin
            n   <= '0;
            ovf <= 1'b0;
          end
        end
        S_WRITE: begin
          board_q <= board_q | write_mask;
          ovf     <= cell_ovf;
          r       <= '0;
        end
        S_SCAN: begin
          if (!row_full && r != LAST_ROW) r <= r + RW'(1);
        end
        S_SHIFT: begin
          for (int k = 0; k < ROWS - 1; k++) begin
            if (k >= int'(r)) board_q[k] <= board_q[k+1];
          end
          board_q[ROWS-1] <= '0;
          if (n != 3'd7) n <= n + 3'd1;
          if (!drop_full && r != LAST_ROW) r <= r + RW'(1);
        end
        S_DONE: begin
          bus.lines_this  <= n;
          bus.lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          bus.score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (ovf) bus.game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.board = board_q;
endmodule

// File: tb/tb_piece_lock_clear.sv
// Bench for piece_lock_clear: directed scenarios plus randomized locks,
// checked against a row-list model of the playfield.
module tb_piece_lock_clear;
  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int SCORE_W = 20;

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piece_lock_clear_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) bus ();

  piece_lock_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model
  board_t m_board;
  int     m_score, m_lines_total, m_lines_this, m_n;
  bit     m_go;

  function automatic logic [3:0][4:0] px(input int a, b, c, d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [3:0][5:0] py(input int a, b, c, d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic model_clear();
    m_board = '0; m_score = 0; m_lines_total = 0; m_lines_this = 0;
    m_n = 0; m_go = 0;
  endtask

  // Drop the piece in, then keep only the rows that are not full, stacked
  // from the bottom; the number removed sets the score.
  task automatic model_lock(input logic [3:0][4:0] xs, input logic [3:0][5:0] ys);
    board_t nb;
    int k, cnt, inc, xi, yi;
    bit ovf;
    ovf = 0;
    for (int i = 0; i < 4; i++) begin
      xi = int'(xs[i]);
      yi = int'(ys[i]);
      if (yi >= ROWS) ovf = 1;
      else if (xi < COLS) m_board[yi][xi] = 1'b1;
    end
    nb = '0; k = 0; cnt = 0;
    for (int row = 0; row < ROWS; row++) begin
      if (m_board[row] == {COLS{1'b1}}) cnt++;
      else begin
        nb[k] = m_board[row];
        k++;
      end
    end
    m_board = nb;
    m_n = cnt;
    inc = (cnt == 0) ? 0 : (cnt == 1) ? 40 : (cnt == 2) ? 100 : (cnt == 3) ? 300 : 1200;
    m_score = (m_score + inc > (1 << SCORE_W) - 1) ? (1 << SCORE_W) - 1 : m_score + inc;
    m_lines_total = (m_lines_total + cnt > 65535) ? 65535 : m_lines_total + cnt;
    m_lines_this = (cnt > 7) ? 7 : cnt;
    if (ovf) m_go = 1;
  endtask

  // drivers
  task automatic pulse_lock(input logic [3:0][4:0] xs, input logic [3:0][5:0] ys);
    @(negedge clk);
    bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
    bus.y0 = ys[0]; bus.y1 = ys[1]; bus.y2 = ys[2]; bus.y3 = ys[3];
    bus.lock_req = 1'b1;
    @(negedge clk);
    bus.lock_req = 1'b0;
  endtask

  // Count edges after the sampling edge until done is seen, then let the
  // DONE edge pass so counters are settled.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_lock(input logic [3:0][4:0] xs, input logic [3:0][5:0] ys,
                         output int lat);
    pulse_lock(xs, ys);
    model_lock(xs, ys);
    wait_done(lat);
  endtask

  task automatic do_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    model_clear();
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.board !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin n_fail++; $display("FAIL reset_board_status: board=%h busy=%b done=%b, want 0/0/0", bus.board, bus.busy, bus.done); end
    n_cmp++;
    if (bus.lines_this !== 3'd0 || bus.lines_total !== 16'd0 || bus.score !== '0 || bus.game_over !== 1'b0)
      begin n_fail++; $display("FAIL reset_counters: lt=%0d ltot=%0d score=%0d go=%b, want 0", bus.lines_this, bus.lines_total, bus.score, bus.game_over); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL post_reset_idle: busy=%b, want 0", bus.busy); end
  endtask

  task automatic test_o_piece();
    int lat;
    do_lock(px(4, 4, 5, 5), py(0, 1, 0, 1), lat);
    n_cmp++;
    if (lat !== 21)
      begin n_fail++; $display("FAIL o_latency: got %0d, want 21", lat); end
    n_cmp++;
    if (bus.board[0] !== 10'b0000110000 || bus.board[1] !== 10'b0000110000 || bus.board !== m_board)
      begin n_fail++; $display("FAIL o_board: got %h, want %h", bus.board, m_board); end
    n_cmp++;
    if (bus.lines_this !== 3'd0 || bus.score !== '0)
      begin n_fail++; $display("FAIL o_counters: lt=%0d score=%0d, want 0/0", bus.lines_this, bus.score); end
  endtask

  task automatic test_single_clear();
    int lat;
    do_new_game();
    do_lock(px(0, 1, 2, 3), py(0, 0, 0, 0), lat);
    do_lock(px(4, 5, 6, 7), py(0, 0, 0, 0), lat);
    do_lock(px(8, 9, 8, 9), py(0, 0, 1, 1), lat);
    n_cmp++;
    if (lat !== 22)
      begin n_fail++; $display("FAIL clear1_latency: got %0d, want 22", lat); end
    n_cmp++;
    if (bus.board[0] !== 10'b1100000000 || bus.board !== m_board)
      begin n_fail++; $display("FAIL clear1_board: got %h, want %h", bus.board, m_board); end
    n_cmp++;
    if (bus.lines_this !== 3'd1 || bus.lines_total !== 16'd1 || bus.score !== 20'd40)
      begin n_fail++; $display("FAIL clear1_counters: lt=%0d ltot=%0d score=%0d, want 1/1/40", bus.lines_this, bus.lines_total, bus.score); end
  endtask

  task automatic test_tetris();
    int lat;
    do_new_game();
    for (int c = 0; c < COLS; c++) begin
      do_lock(px(c, c, c, c), py(0, 1, 2, 3), lat);
      n_cmp++;
      if (lat !== 21 + m_n)
        begin n_fail++; $display("FAIL tetris_latency col %0d: got %0d, want %0d", c, lat, 21 + m_n); end
      n_cmp++;
      if (bus.board !== m_board)
        begin n_fail++; $display("FAIL tetris_board col %0d: got %h, want %h", c, bus.board, m_board); end
    end
    n_cmp++;
    if (lat !== 25 || bus.board !== '0 || bus.lines_this !== 3'd4 || bus.score !== 20'd1200)
      begin n_fail++; $display("FAIL tetris_final: lat=%0d lt=%0d score=%0d board=%h, want 25/4/1200/0", lat, bus.lines_this, bus.score, bus.board); end
  endtask

  task automatic test_overflow();
    int lat, dones;
    board_t snap;
    do_new_game();
    do_lock(px(2, 3, 4, 5), py(0, 0, 0, 20), lat);
    n_cmp++;
    if (lat !== 21 || bus.board !== m_board)
      begin n_fail++; $display("FAIL ovf_lock: lat=%0d board=%h, want 21 board=%h", lat, bus.board, m_board); end
    n_cmp++;
    if (bus.game_over !== 1'b1 || bus.busy !== 1'b0 || bus.game_over !== m_go)
      begin n_fail++; $display("FAIL ovf_flag: go=%b busy=%b, want 1/0", bus.game_over, bus.busy); end
    snap = bus.board;
    pulse_lock(px(0, 1, 2, 3), py(5, 5, 5, 5));
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || bus.board !== m_board || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL over_ignores_lock: dones=%0d busy=%b board=%h, want 0/0 board=%h", dones, bus.busy, bus.board, snap); end
    do_new_game();
    #1;
    n_cmp++;
    if (bus.board !== '0 || bus.score !== '0 || bus.game_over !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL over_new_game: board=%h score=%0d go=%b busy=%b, want all 0", bus.board, bus.score, bus.game_over, bus.busy); end
  endtask

  task automatic test_ignore_busy();
    int dones, first;
    do_new_game();
    do_lock(px(0, 1, 2, 3), py(0, 0, 0, 0), first);
    pulse_lock(px(0, 1, 2, 3), py(5, 5, 5, 6));
    model_lock(px(0, 1, 2, 3), py(5, 5, 5, 6));
    dones = 0; first = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) first = c;
      end
      bus.lock_req = (c == 3);
      bus.new_game = (c == 5);
    end
    bus.lock_req = 1'b0;
    bus.new_game = 1'b0;
    n_cmp++;
    if (dones !== 1 || first !== 21 + m_n)
      begin n_fail++; $display("FAIL busy_single_done: dones=%0d first=%0d, want 1/%0d", dones, first, 21 + m_n); end
    n_cmp++;
    if (bus.board !== m_board)
      begin n_fail++; $display("FAIL busy_board: got %h, want %h", bus.board, m_board); end
  endtask

  task automatic test_reset_mid();
    int lat, dones;
    do_new_game();
    do_lock(px(0, 1, 2, 3), py(0, 0, 0, 0), lat);
    do_lock(px(4, 5, 6, 7), py(0, 0, 0, 0), lat);
    pulse_lock(px(8, 9, 8, 9), py(0, 0, 1, 1));
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.board !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.score !== '0 ||
        bus.lines_total !== 16'd0 || bus.lines_this !== 3'd0 || bus.game_over !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_outputs: board=%h busy=%b done=%b score=%0d, want all 0", bus.board, bus.busy, bus.done, bus.score); end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0)
      begin n_fail++; $display("FAIL reset_mid_no_done: dones=%0d, want 0", dones); end
    do_lock(px(4, 4, 5, 5), py(0, 1, 0, 1), lat);
    n_cmp++;
    if (lat !== 21 || bus.board !== m_board || bus.score !== '0)
      begin n_fail++; $display("FAIL reset_mid_recover: lat=%0d board=%h, want 21 board=%h", lat, bus.board, m_board); end
  endtask

  task automatic test_random_back_to_back();
    int lat;
    logic [3:0][4:0] xs;
    logic [3:0][5:0] ys;
    do_new_game();
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = 5'($urandom_range(0, 10));
        ys[i] = 6'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) == 0) ys[3] = ($urandom_range(0, 1) == 1) ? 6'd20 : 6'h3F;
      do_lock(xs, ys, lat);
      n_cmp++;
      if (lat !== 21 + m_n)
        begin n_fail++; $display("FAIL rand_latency it %0d: got %0d, want %0d", it, lat, 21 + m_n); end
      n_cmp++;
      if (bus.board !== m_board)
        begin n_fail++; $display("FAIL rand_board it %0d: got %h, want %h", it, bus.board, m_board); end
      n_cmp++;
      if (bus.lines_this !== 3'(m_lines_this) || bus.lines_total !== 16'(m_lines_total) ||
          bus.score !== SCORE_W'(m_score) || bus.game_over !== m_go)
        begin n_fail++; $display("FAIL rand_counters it %0d: lt=%0d ltot=%0d score=%0d go=%b, want %0d/%0d/%0d/%b",
                                 it, bus.lines_this, bus.lines_total, bus.score, bus.game_over,
                                 m_lines_this, m_lines_total, m_score, m_go); end
      if (m_go) do_new_game();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.lock_req = 1'b0; bus.new_game = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0; bus.y3 = '0;
    test_reset();
    test_o_piece();
    test_single_clear();
    test_tetris();
    test_overflow();
    test_ignore_busy();
    test_reset_mid();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
